// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 key tracker. Holds the
//               prefix and modifier scan codes, the handshake FSM state
//               encoding, the held-key table entry type, and a small
//               letter-range helper used for Shift/Caps handling.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_CAPS   = 8'h58;

  // Byte handshake with the receive FIFO
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_GAP  = 2'd2
  } ps2_state_t;

  // One slot of the held-key table; identity is the full {ext, code} pair
  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } held_entry_t;

  // True for lowercase ASCII letters 'a'..'z'
  function automatic logic is_lower(input logic [7:0] a);
    return (a >= 8'h61) && (a <= 8'h7A);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_scan2ascii.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scan2ascii
// Description : Combinational PS/2 set-2 scan code to ASCII lookup.
//               Returns lowercase letters, digits, space and carriage
//               return; every other code maps to 0x00.
// Ports       : scan  [7:0] in  - scan code without prefixes
//               ascii [7:0] out - unshifted ASCII value or 0x00
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scan2ascii (
  input  logic [7:0] scan,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    case (scan)
      8'h1C: ascii = 8'h61; // a
      8'h32: ascii = 8'h62; // b
      8'h21: ascii = 8'h63; // c
      8'h23: ascii = 8'h64; // d
      8'h24: ascii = 8'h65; // e
      8'h2B: ascii = 8'h66; // f
      8'h34: ascii = 8'h67; // g
      8'h33: ascii = 8'h68; // h
      8'h43: ascii = 8'h69; // i
      8'h3B: ascii = 8'h6A; // j
      8'h42: ascii = 8'h6B; // k
      8'h4B: ascii = 8'h6C; // l
      8'h3A: ascii = 8'h6D; // m
      8'h31: ascii = 8'h6E; // n
      8'h44: ascii = 8'h6F; // o
      8'h4D: ascii = 8'h70; // p
      8'h15: ascii = 8'h71; // q
      8'h2D: ascii = 8'h72; // r
      8'h1B: ascii = 8'h73; // s
      8'h2C: ascii = 8'h74; // t
      8'h3C: ascii = 8'h75; // u
      8'h2A: ascii = 8'h76; // v
      8'h1D: ascii = 8'h77; // w
      8'h22: ascii = 8'h78; // x
      8'h35: ascii = 8'h79; // y
      8'h1A: ascii = 8'h7A; // z
      8'h45: ascii = 8'h30; // 0
      8'h16: ascii = 8'h31; // 1
      8'h1E: ascii = 8'h32; // 2
      8'h26: ascii = 8'h33; // 3
      8'h25: ascii = 8'h34; // 4
      8'h2E: ascii = 8'h35; // 5
      8'h36: ascii = 8'h36; // 6
      8'h3D: ascii = 8'h37; // 7
      8'h3E: ascii = 8'h38; // 8
      8'h46: ascii = 8'h39; // 9
      8'h29: ascii = 8'h20; // space
      8'h5A: ascii = 8'h0D; // enter
      default: ascii = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_tracker
// Description : Pops bytes from the PS/2 receive FIFO (one per 3 cycles),
//               decodes E0/F0 prefixes, tracks up to MAX_HELD held keys,
//               applies Shift/Caps Lock to ASCII and keeps a BCD press count.
// Parameters  : MAX_HELD   - held-key table depth (>=1)
//               CNT_DIGITS - BCD digits in press_cnt (>=1)
// Macro       : PS2_TYPEMATIC_FILTER_EN - when defined, repeat makes of an
//               already-held key do not increment press_cnt.
// Ports       : clk, clr (async active-high reset)
//               rx_data/rx_ready  - FIFO head byte / non-empty flag
//               rx_next_n         - active-low pop strobe
//               key_code/key_ext/key_ascii - last pressed key
//               disp_en, held_cnt, held_ovf - held-key table status
//               shift, caps       - modifier state
//               press_cnt         - BCD press counter, digit 0 in [3:0]
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_tracker #(
  parameter int MAX_HELD   = 4,
  parameter int CNT_DIGITS = 2
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_ready,
  output logic                         rx_next_n,
  output logic [7:0]                   key_code,
  output logic                         key_ext,
  output logic [7:0]                   key_ascii,
  output logic                         disp_en,
  output logic [$clog2(MAX_HELD+1)-1:0] held_cnt,
  output logic                         held_ovf,
  output logic                         shift,
  output logic                         caps,
  output logic [4*CNT_DIGITS-1:0]      press_cnt
);
  import ps2_pkg::*;

  localparam int              HCW     = $clog2(MAX_HELD + 1);
  localparam logic [HCW-1:0]  CNT_ONE = HCW'(1);

  // Handshake FSM
  ps2_state_t state, state_nx;

  // Byte in flight and prefix flags
  logic [7:0]  byte_q;
  logic        ext_f, brk_f, ext_nx, brk_nx;

  // Held-key table, entries [0 .. held_cnt-1] valid and packed to the front
  held_entry_t tbl    [MAX_HELD];
  held_entry_t tbl_nx [MAX_HELD];
  held_entry_t cur;

  // Modifier bits
  logic lshift_b, rshift_b, caps_down;
  logic ls_nx, rs_nx, cdown_nx, caps_nx;

  // Output next values
  logic [7:0]            code_nx, ascii_nx;
  logic                  kext_nx, disp_nx, ovf_nx;
  logic [HCW-1:0]        cnt_nx;
  logic [4*CNT_DIGITS-1:0] press_inc, press_nx;
  logic                  cnt_inc, bcd_carry;

  // Lookup and table search results
  logic [7:0] raw_ascii, adj_ascii;
  logic       hit;
  int         hit_idx;

  ps2_scan2ascii u_lut (
    .scan  (byte_q),
    .ascii (raw_ascii)
  );

  assign shift = lshift_b | rshift_b;
  assign cur   = {ext_f, byte_q};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    rx_next_n = 1'b1;
    case (state)
      S_IDLE: if (rx_ready) state_nx = S_POP;
      S_POP: begin
        rx_next_n = 1'b0;
        state_nx  = S_GAP;
      end
      S_GAP:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- ASCII / BCD
  // Letters only take Shift xor Caps; extended keys never map.
  always_comb begin
    adj_ascii = raw_ascii;
    if (ext_f) begin
      adj_ascii = 8'h00;
    end else if (is_lower(raw_ascii) && (shift ^ caps)) begin
      adj_ascii = raw_ascii - 8'h20;
    end
  end

  always_comb begin
    press_inc = press_cnt;
    bcd_carry = 1'b1;
    for (int d = 0; d < CNT_DIGITS; d++) begin
      if (bcd_carry) begin
        if (press_cnt[4*d +: 4] == 4'd9) begin
          press_inc[4*d +: 4] = 4'd0;
        end else begin
          press_inc[4*d +: 4] = press_cnt[4*d +: 4] + 4'd1;
          bcd_carry = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------- table search
  always_comb begin
    hit     = 1'b0;
    hit_idx = 0;
    for (int i = 0; i < MAX_HELD; i++) begin
      if (!hit && (i < int'(held_cnt)) && (tbl[i] == cur)) begin
        hit     = 1'b1;
        hit_idx = i;
      end
    end
  end

  // ----------------------------------------------------------- decode
  // Next values default to current; only the POP cycle changes anything.
  always_comb begin
    ext_nx   = ext_f;
    brk_nx   = brk_f;
    tbl_nx   = tbl;
    cnt_nx   = held_cnt;
    ovf_nx   = held_ovf;
    code_nx  = key_code;
    kext_nx  = key_ext;
    ascii_nx = key_ascii;
    disp_nx  = disp_en;
    ls_nx    = lshift_b;
    rs_nx    = rshift_b;
    caps_nx  = caps;
    cdown_nx = caps_down;
    cnt_inc  = 1'b0;

    if (state == S_POP) begin
      if (byte_q == PS2_EXT) begin
        ext_nx = 1'b1;
      end else if (byte_q == PS2_BRK) begin
        brk_nx = 1'b1;
      end else begin
        ext_nx = 1'b0;
        brk_nx = 1'b0;
        if (!ext_f && (byte_q == PS2_LSHIFT)) begin
          ls_nx = !brk_f;
        end else if (!ext_f && (byte_q == PS2_RSHIFT)) begin
          rs_nx = !brk_f;
        end else if (!ext_f && (byte_q == PS2_CAPS)) begin
          // Typematic repeats of Caps arrive while caps_down is set
          if (!brk_f) begin
            if (!caps_down) caps_nx = !caps;
            cdown_nx = 1'b1;
          end else begin
            cdown_nx = 1'b0;
          end
        end else if (!brk_f) begin
          code_nx  = byte_q;
          kext_nx  = ext_f;
          ascii_nx = adj_ascii;
          disp_nx  = 1'b1;
          if (!hit) begin
            cnt_inc = 1'b1;
            if (int'(held_cnt) < MAX_HELD) begin
              for (int i = 0; i < MAX_HELD; i++) begin
                if (i == int'(held_cnt)) tbl_nx[i] = cur;
              end
              cnt_nx = held_cnt + CNT_ONE;
            end else begin
              ovf_nx = 1'b1;
            end
          end else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
            cnt_inc = 1'b0;
`else
            cnt_inc = 1'b1;
`endif
          end
        end else if (hit) begin
          // Close the gap left by the released key
          for (int i = 0; i < MAX_HELD - 1; i++) begin
            if (i >= hit_idx) tbl_nx[i] = tbl[i+1];
          end
          tbl_nx[MAX_HELD-1] = '0;
          cnt_nx  = held_cnt - CNT_ONE;
          disp_nx = (held_cnt != CNT_ONE);
        end
      end
    end
  end

  assign press_nx = cnt_inc ? press_inc : press_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      byte_q    <= 8'h00;
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      held_cnt  <= '0;
      held_ovf  <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_ascii <= 8'h00;
      disp_en   <= 1'b0;
      lshift_b  <= 1'b0;
      rshift_b  <= 1'b0;
      caps      <= 1'b0;
      caps_down <= 1'b0;
      press_cnt <= '0;
      for (int i = 0; i < MAX_HELD; i++) tbl[i] <= '0;
    end else begin
      if ((state == S_IDLE) && rx_ready) byte_q <= rx_data;
      ext_f     <= ext_nx;
      brk_f     <= brk_nx;
      held_cnt  <= cnt_nx;
      held_ovf  <= ovf_nx;
      key_code  <= code_nx;
      key_ext   <= kext_nx;
      key_ascii <= ascii_nx;
      disp_en   <= disp_nx;
      lshift_b  <= ls_nx;
      rshift_b  <= rs_nx;
      caps      <= caps_nx;
      caps_down <= cdown_nx;
      press_cnt <= press_nx;
      for (int i = 0; i < MAX_HELD; i++) tbl[i] <= tbl_nx[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_tracker
// Description : Self-checking bench for ps2_key_tracker. A FIFO model feeds
//               bytes and pops on each strobe; a key-level reference model
//               (queue of held keys, integer press count) is compared with
//               every DUT output on each falling edge, and directed
//               scenarios pin literal expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_tracker;

  localparam int MAX_HELD   = 4;
  localparam int CNT_DIGITS = 2;
  localparam int HCW        = $clog2(MAX_HELD + 1);

  logic                    clk = 1'b0;
  logic                    clr = 1'b1;
  logic [7:0]              rx_data = 8'h00;
  logic                    rx_ready = 1'b0;
  logic                    rx_next_n;
  logic [7:0]              key_code;
  logic                    key_ext;
  logic [7:0]              key_ascii;
  logic                    disp_en;
  logic [HCW-1:0]          held_cnt;
  logic                    held_ovf;
  logic                    shift;
  logic                    caps;
  logic [4*CNT_DIGITS-1:0] press_cnt;

  ps2_key_tracker #(.MAX_HELD(MAX_HELD), .CNT_DIGITS(CNT_DIGITS)) dut (
    .clk(clk), .clr(clr), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_next_n(rx_next_n), .key_code(key_code), .key_ext(key_ext),
    .key_ascii(key_ascii), .disp_en(disp_en), .held_cnt(held_cnt),
    .held_ovf(held_ovf), .shift(shift), .caps(caps), .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- reference model
  logic [7:0] fifo[$];
  int         held[$];          // {ext, code} of each held key
  bit         m_ext, m_brk, m_ls, m_rs, m_caps, m_cdown, m_ovf, m_disp, m_kext;
  logic [7:0] m_code, m_ascii;
  int         m_presses;

  logic [7:0] lc [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                          8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                          8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] dc [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};

  function automatic logic [7:0] ascii_of(input logic [7:0] b, input bit e, input bit up);
    if (e) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (lc[i] == b) return up ? 8'(65 + i) : 8'(97 + i);
    for (int i = 0; i < 10; i++)
      if (dc[i] == b) return 8'(48 + i);
    if (b == 8'h29) return 8'h20;
    if (b == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  function automatic logic [4*CNT_DIGITS-1:0] to_bcd(input int n);
    logic [4*CNT_DIGITS-1:0] r;
    int v;
    r = '0;
    v = n;
    for (int d = 0; d < CNT_DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int modulus();
    int m = 1;
    for (int d = 0; d < CNT_DIGITS; d++) m = m * 10;
    return m;
  endfunction

  task automatic model_reset();
    held.delete();
    fifo.delete();
    m_ext = 0; m_brk = 0; m_ls = 0; m_rs = 0; m_caps = 0; m_cdown = 0;
    m_ovf = 0; m_disp = 0; m_kext = 0; m_code = 0; m_ascii = 0; m_presses = 0;
  endtask

  task automatic model_apply(input logic [7:0] b);
    bit e, br;
    int key, idx;
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    e = m_ext; br = m_brk; m_ext = 0; m_brk = 0;
    if (!e && b == 8'h12) begin m_ls = !br; return; end
    if (!e && b == 8'h59) begin m_rs = !br; return; end
    if (!e && b == 8'h58) begin
      if (!br) begin
        if (!m_cdown) m_caps = !m_caps;
        m_cdown = 1;
      end else m_cdown = 0;
      return;
    end
    key = {23'd0, e, b};
    idx = -1;
    foreach (held[i]) if (idx < 0 && held[i] == key) idx = i;
    if (!br) begin
      m_code = b; m_kext = e; m_disp = 1;
      m_ascii = ascii_of(b, e, (m_ls | m_rs) ^ m_caps);
      if (idx < 0) begin
        if (held.size() < MAX_HELD) held.push_back(key); else m_ovf = 1;
        m_presses = (m_presses + 1) % modulus();
      end else begin
`ifndef PS2_TYPEMATIC_FILTER_EN
        m_presses = (m_presses + 1) % modulus();
`endif
      end
    end else if (idx >= 0) begin
      held.delete(idx);
      if (held.size() == 0) m_disp = 0;
    end
  endtask

  // ------------------------------------------ compare + FIFO pop process
  int cyc = 0;
  int last_pop = -100;
  bit pop_cont = 0;

  always @(negedge clk) begin
    cyc++;
    if (clr) begin
      model_reset();
      last_pop = -100;
      pop_cont = 0;
    end
    chk("key_code",  32'(key_code),  32'(m_code));
    chk("key_ext",   32'(key_ext),   32'(m_kext));
    chk("key_ascii", 32'(key_ascii), 32'(m_ascii));
    chk("disp_en",   32'(disp_en),   32'(m_disp));
    chk("held_cnt",  32'(held_cnt),  32'(held.size()));
    chk("held_ovf",  32'(held_ovf),  32'(m_ovf));
    chk("shift",     32'(shift),     32'(m_ls | m_rs));
    chk("caps",      32'(caps),      32'(m_caps));
    chk("press_cnt", 32'(press_cnt), 32'(to_bcd(m_presses)));
    if (clr) chk("rx_next_n_rst", 32'(rx_next_n), 32'd1);
    if (!clr && rx_next_n == 1'b0) begin
      chk("strobe_width", 32'(cyc - last_pop > 1), 32'd1);
      if (pop_cont) chk("strobe_period", 32'(cyc - last_pop), 32'd3);
      if (fifo.size() == 0) begin
        chk("pop_underflow", 32'd1, 32'd0);
      end else begin
        model_apply(fifo.pop_front());
      end
      last_pop = cyc;
      pop_cont = (fifo.size() != 0);
    end
    rx_ready = (fifo.size() != 0);
    rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  // ----------------------------------------------------------- stimulus
  task automatic send(input logic [7:0] b);
    @(posedge clk); #2;
    fifo.push_back(b);
  endtask

  task automatic drain();
    int n = 0;
    while (fifo.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) chk("drain_timeout", 32'd1, 32'd0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    // Reset state
    chk("rst_rx_next_n", 32'(rx_next_n), 32'd1);
    chk("rst_key_code",  32'(key_code),  32'h00);
    chk("rst_press_cnt", 32'(press_cnt), 32'h00);
    chk("rst_held_cnt",  32'(held_cnt),  32'd0);
    clr = 1'b0;
    repeat (2) @(posedge clk);

    // Single key press/release
    send(8'h1C); drain();
    chk("t1_code",  32'(key_code),  32'h1C);
    chk("t1_ascii", 32'(key_ascii), 32'h61);
    chk("t1_disp",  32'(disp_en),   32'd1);
    chk("t1_held",  32'(held_cnt),  32'd1);
    send(8'hF0); send(8'h1C); drain();
    chk("t1_disp_off", 32'(disp_en),   32'd0);
    chk("t1_held0",    32'(held_cnt),  32'd0);
    chk("t1_press",    32'(press_cnt), 32'h01);

    // Shifted letter
    do_reset();
    send(8'h12); send(8'h1C); drain();
    chk("t2_ascii", 32'(key_ascii), 32'h41);
    chk("t2_shift", 32'(shift),     32'd1);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); drain();
    chk("t2_shift0", 32'(shift),     32'd0);
    chk("t2_press",  32'(press_cnt), 32'h01);

    // Extended key
    do_reset();
    send(8'hE0); send(8'h75); drain();
    chk("t3_ext",   32'(key_ext),   32'd1);
    chk("t3_code",  32'(key_code),  32'h75);
    chk("t3_ascii", 32'(key_ascii), 32'h00);
    send(8'hE0); send(8'hF0); send(8'h75); drain();
    chk("t3_held0", 32'(held_cnt), 32'd0);

    // Table overflow
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h2B); drain();
    chk("t4_held",  32'(held_cnt),  32'd4);
    chk("t4_ovf",   32'(held_ovf),  32'd1);
    chk("t4_press", 32'(press_cnt), 32'h05);
    chk("t4_code",  32'(key_code),  32'h2B);

    // Typematic repeats
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); drain();
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("t5_press", 32'(press_cnt), 32'h01);
`else
    chk("t5_press", 32'(press_cnt), 32'h03);
`endif

    // BCD wrap
    do_reset();
    for (int i = 0; i < 99; i++) begin
      send(lc[i % 26]); send(8'hF0); send(lc[i % 26]);
    end
    drain();
    chk("t6_press99", 32'(press_cnt), 32'h99);
    send(8'h29); send(8'hF0); send(8'h29); drain();
    chk("t6_wrap", 32'(press_cnt), 32'h00);
    chk("t6_space", 32'(key_ascii), 32'h20);

    // Caps Lock with repeat, then Shift cancelling it, digit unaffected
    do_reset();
    send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h1C); drain();
    chk("t7_caps",  32'(caps),      32'd1);
    chk("t7_upper", 32'(key_ascii), 32'h41);
    send(8'h59); send(8'h1C); drain();
    chk("t7_lower", 32'(key_ascii), 32'h61);
    send(8'h16); drain();
    chk("t7_digit", 32'(key_ascii), 32'h31);
    send(8'h58); send(8'hF0); send(8'h58); drain();
    chk("t7_caps0", 32'(caps), 32'd0);

    // Reset drops a pending prefix
    do_reset();
    send(8'hE0); drain();
    do_reset();
    send(8'h1C); drain();
    chk("t8_ext",   32'(key_ext),   32'd0);
    chk("t8_ascii", 32'(key_ascii), 32'h61);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
